sumcheck_prover: RTL and testbench
==================================

Name: sumcheck_prover

Overview:
- Prover end of the per-layer sumcheck exchange in the CMT hardware.
- Holds two multilinear evaluation tables A and B over {0,1}^NUM_BITS and proves the claimed sum of A(x)*B(x) mod MODULUS.
- Each round it emits the three sample points g(0), g(1), g(2) of the degree-2 round polynomial, takes the verifier's random challenge, and folds its tables.
- After NUM_BITS rounds it reports A(r) and B(r) for the verifier's final check.

Parameters:
- UINT_WIDTH, 32: field element width.
- NUM_BITS, 3: number of sumcheck variables; table depth N = 2^NUM_BITS.
- MODULUS, 2147483647: prime field modulus, MODULUS < 2^UINT_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- load_valid  in  1  write one table entry, accepted only in IDLE.
- load_idx  in  NUM_BITS  entry index.
- load_a  in  UINT_WIDTH  A value.
- load_b  in  UINT_WIDTH  B value.
- start  in  1  begin proof, accepted only in IDLE.
- sample_pts  out  UINT_WIDTH x [3]  g(0), g(1), g(2) of the current round.
- pts_valid  out  1  sample_pts valid.
- pts_ready  in  1  verifier consumes sample_pts.
- challenge  in  UINT_WIDTH  round random value r_j.
- chal_valid  in  1  challenge offered.
- chal_ready  out  1  prover accepts challenge.
- final_a  out  UINT_WIDTH  A(r_1..r_n).
- final_b  out  UINT_WIDTH  B(r_1..r_n).
- done  out  1  final values valid; held high until next start.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- Reset values: sample_pts=0, pts_valid=0, chal_ready=0, final_a=0, final_b=0, done=0, busy=0, FSM=IDLE, round=0, len=N. Table contents are not cleared.
- Arithmetic: every value is in [0, MODULUS).
  - load_a, load_b and challenge are reduced mod MODULUS when captured.
  - Additions and subtractions use conditional ±MODULUS.
  - Products are formed at 2*UINT_WIDTH and reduced mod MODULUS.
- FSM states:
  - IDLE: load_valid writes A[load_idx], B[load_idx]. start moves to EVAL with len=N, k=0, sums=0, done=0. If load_valid and start coincide, the write happens and start is also taken.
  - EVAL: one pair (a0,a1)=(A[2k],A[2k+1]), (b0,b1) likewise per cycle.
    - s0+=a0*b0; s1+=a1*b1; s2+=(2a1-a0)*(2b1-b0).
    - After k=len/2-1 go to SEND.
    - Takes len/2 cycles.
  - SEND: sample_pts={s0,s1,s2}, pts_valid=1. Values are stable while pts_valid && !pts_ready. The handshake completes in the cycle both are high, then go to WAIT_CHAL.
  - WAIT_CHAL: chal_ready=1. On chal_valid, capture r and go to FOLD. chal_valid outside WAIT_CHAL is ignored.
  - FOLD: per cycle, A[k]=a0+r*(a1-a0) and B[k]=b0+r*(b1-b0) for k=0..len/2-1, written in place (index k ≤ 2k, so no hazard).
    - Then len=len/2 and round++.
    - If round==NUM_BITS go to DONE, else EVAL with sums cleared.
  - DONE: final_a=A[0], final_b=B[0], done=1, busy=0, return to IDLE. done stays high until the next accepted start.
- Latency:
  - pts_valid rises len/2+1 cycles after the start (or challenge) accept edge.
  - FOLD takes len/2 cycles.
  - Last round: len=2, one EVAL cycle, one FOLD cycle.
- Boundary conditions:
  - start while busy: ignored.
  - load_valid while busy: ignored; the table is not modified.
  - pts_ready while not in SEND: no effect.
  - rst mid-round: immediately returns to IDLE with the reset values above; the partially folded table is left as is and must be reloaded.
  - NUM_BITS=1: a single round.

Decomposition:
- Package cmt_pkg: UINT_WIDTH, MODULUS, typedef felem_t (logic [UINT_WIDTH-1:0]), prover FSM state enum, and functions mod_add / mod_sub.
- One sub-module, mod_mul: combinational a*b mod MODULUS. Instantiate it three times in EVAL; FOLD shares two of those instances.

Test Plan:
- A=[1..8], B=all 1, start -> round 1 pts {16,20,24}; challenge 0 -> {6,10,14}; challenge 1 -> {3,7,11}; challenge 2 -> done, final_a=11, final_b=1.
- A=[MODULUS-1,0,0,0,0,0,0,0], B=all 1 -> round 1 pts {MODULUS-1, 0, 1}, which checks mod-subtraction wrap.
- Hold pts_ready=0 for 5 cycles in SEND -> pts_valid and sample_pts stable. Assert chal_valid during SEND -> ignored; chal_ready=0 until WAIT_CHAL.
- Pulse start and load_valid during EVAL -> no restart and no table change; results equal the first scenario.
- Assert rst during round-2 FOLD -> next cycle busy=0, pts_valid=0, done=0. Reload and rerun the first scenario -> identical outputs.
- challenge=MODULUS+2 in the last round of the first scenario -> reduced to 2, final_a=11.

Source files
------------

// File: rtl/cmt_pkg.sv
// Shared field arithmetic and prover state encoding for the CMT sumcheck blocks.
// Values are elements of GF(MODULUS), held in UINT_WIDTH-bit words.
package cmt_pkg;

    localparam int UINT_WIDTH = 32;

    typedef logic [UINT_WIDTH-1:0] felem_t;

    localparam felem_t MODULUS = felem_t'(64'd2147483647);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EVAL      = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_CHAL = 3'd3,
        ST_FOLD      = 3'd4,
        ST_DONE      = 3'd5
    } prover_state_t;

    // Full reduction of an arbitrary word into the field.
    function automatic felem_t mod_red(input felem_t v);
        return v % MODULUS;
    endfunction

    // Operands are already reduced, so one conditional subtract suffices.
    function automatic felem_t mod_add(input felem_t a, input felem_t b);
        logic [UINT_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= {1'b0, MODULUS}) ? felem_t'(s - {1'b0, MODULUS}) : felem_t'(s);
    endfunction

    function automatic felem_t mod_sub(input felem_t a, input felem_t b);
        return (a >= b) ? (a - b) : (a + (MODULUS - b));
    endfunction

endpackage

// File: rtl/sumcheck_prover_mod_mul.sv
// Combinational modular multiply: product formed at double width, then reduced.
// Zero latency; no flow control.
module mod_mul
    import cmt_pkg::*;
(
    input  felem_t a,
    input  felem_t b,
    output felem_t p
);

    localparam int PW = 2 * UINT_WIDTH;

    logic [PW-1:0] prod;

    assign prod = PW'(a) * PW'(b);
    assign p    = felem_t'(prod % PW'(MODULUS));

endmodule

// File: rtl/sumcheck_prover.sv
// Sumcheck prover: per round emits g(0),g(1),g(2) of sum A*B, takes a challenge, folds tables.
// EVAL and FOLD each take len/2 cycles; SEND holds sample_pts until pts_ready.
module sumcheck_prover
    import cmt_pkg::*;
#(
    parameter int NUM_BITS = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_valid,
    input  logic [NUM_BITS-1:0]         load_idx,
    input  felem_t                      load_a,
    input  felem_t                      load_b,
    input  logic                        start,
    output logic [2:0][UINT_WIDTH-1:0]  sample_pts,
    output logic                        pts_valid,
    input  logic                        pts_ready,
    input  felem_t                      challenge,
    input  logic                        chal_valid,
    output logic                        chal_ready,
    output felem_t                      final_a,
    output felem_t                      final_b,
    output logic                        done,
    output logic                        busy
);

    localparam int N  = 1 << NUM_BITS;
    localparam int RW = $clog2(NUM_BITS + 1);

    prover_state_t       state;
    logic [NUM_BITS:0]   len;
    logic [NUM_BITS-1:0] k;
    logic [RW-1:0]       round;
    felem_t              s0, s1, s2, r;

    felem_t tab_a [N];
    felem_t tab_b [N];

    logic [NUM_BITS-1:0] idx_lo, idx_hi, half_m1;
    logic                last_pair;
    logic                in_fold;
    felem_t              a0, a1, b0, b1;
    felem_t              da, db, ea, eb;
    felem_t              m0_a, m0_b, m1_a, m1_b;
    felem_t              m0, m1, m2;
    felem_t              fold_a, fold_b;

    assign idx_lo    = k << 1;
    assign idx_hi    = idx_lo | NUM_BITS'(1);
    assign half_m1   = NUM_BITS'((len >> 1) - 1'b1);
    assign last_pair = (k == half_m1);
    assign in_fold   = (state == ST_FOLD);

    assign a0 = tab_a[idx_lo];
    assign a1 = tab_a[idx_hi];
    assign b0 = tab_b[idx_lo];
    assign b1 = tab_b[idx_hi];

    assign da = mod_sub(a1, a0);
    assign db = mod_sub(b1, b0);
    // Line through (0,a0),(1,a1) evaluated at x=2.
    assign ea = mod_sub(mod_add(a1, a1), a0);
    assign eb = mod_sub(mod_add(b1, b1), b0);

    // FOLD borrows the g(0)/g(1) multipliers for r*(a1-a0) and r*(b1-b0).
    assign m0_a = in_fold ? r  : a0;
    assign m0_b = in_fold ? da : b0;
    assign m1_a = in_fold ? r  : a1;
    assign m1_b = in_fold ? db : b1;

    mod_mul u_mul0 (.a(m0_a), .b(m0_b), .p(m0));
    mod_mul u_mul1 (.a(m1_a), .b(m1_b), .p(m1));
    mod_mul u_mul2 (.a(ea),   .b(eb),   .p(m2));

    assign fold_a = mod_add(a0, m0);
    assign fold_b = mod_add(b0, m1);

    assign busy = (state != ST_IDLE);

    // Table contents survive reset; a reset mid-fold leaves them partially folded.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_IDLE && load_valid) begin
                tab_a[load_idx] <= mod_red(load_a);
                tab_b[load_idx] <= mod_red(load_b);
            end else if (in_fold) begin
                tab_a[k] <= fold_a;
                tab_b[k] <= fold_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            len        <= (NUM_BITS + 1)'(N);
            k          <= '0;
            round      <= '0;
            s0         <= '0;
            s1         <= '0;
            s2         <= '0;
            r          <= '0;
            sample_pts <= '0;
            pts_valid  <= 1'b0;
            chal_ready <= 1'b0;
            final_a    <= '0;
            final_b    <= '0;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_EVAL;
                        len   <= (NUM_BITS + 1)'(N);
                        k     <= '0;
                        round <= '0;
                        s0    <= '0;
                        s1    <= '0;
                        s2    <= '0;
                        done  <= 1'b0;
                    end
                end
                ST_EVAL: begin
                    s0 <= mod_add(s0, m0);
                    s1 <= mod_add(s1, m1);
                    s2 <= mod_add(s2, m2);
                    if (last_pair) begin
                        k     <= '0;
                        state <= ST_SEND;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                ST_SEND: begin
                    if (!pts_valid) begin
                        sample_pts <= {s2, s1, s0};
                        pts_valid  <= 1'b1;
                    end else if (pts_ready) begin
                        pts_valid  <= 1'b0;
                        chal_ready <= 1'b1;
                        state      <= ST_WAIT_CHAL;
                    end
                end
                ST_WAIT_CHAL: begin
                    if (chal_valid) begin
                        r          <= mod_red(challenge);
                        chal_ready <= 1'b0;
                        k          <= '0;
                        state      <= ST_FOLD;
                    end
                end
                ST_FOLD: begin
                    if (last_pair) begin
                        k     <= '0;
                        len   <= len >> 1;
                        round <= round + 1'b1;
                        s0    <= '0;
                        s1    <= '0;
                        s2    <= '0;
                        state <= (round == RW'(NUM_BITS - 1)) ? ST_DONE : ST_EVAL;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                ST_DONE: begin
                    final_a <= tab_a[0];
                    final_b <= tab_b[0];
                    done    <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sumcheck_prover.sv
// Directed and randomized proofs of sumcheck_prover against an arithmetic reference model.
module tb_sumcheck_prover;
    import cmt_pkg::*;

    localparam int NB = 3;
    localparam int N  = 8;
    localparam longint unsigned M = 64'(MODULUS);

    logic                clk = 1'b0;
    logic                rst;
    logic                load_valid;
    logic [NB-1:0]       load_idx;
    logic [31:0]         load_a, load_b;
    logic                start;
    logic [2:0][31:0]    sample_pts;
    logic                pts_valid;
    logic                pts_ready;
    logic [31:0]         challenge;
    logic                chal_valid;
    logic                chal_ready;
    logic [31:0]         final_a, final_b;
    logic                done;
    logic                busy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0]       ta [N];
    logic [31:0]       tbv [N];
    logic [31:0]       chal [NB];
    logic [2:0][31:0]  first_pts;
    longint unsigned   ma [N];
    longint unsigned   mb [N];

    sumcheck_prover #(.NUM_BITS(NB)) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_idx(load_idx), .load_a(load_a), .load_b(load_b),
        .start(start),
        .sample_pts(sample_pts), .pts_valid(pts_valid), .pts_ready(pts_ready),
        .challenge(challenge), .chal_valid(chal_valid), .chal_ready(chal_ready),
        .final_a(final_a), .final_b(final_b), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_all;
        for (int i = 0; i < N; i++) begin
            load_valid = 1'b1;
            load_idx   = NB'(i);
            load_a     = ta[i];
            load_b     = tbv[i];
            tick();
        end
        load_valid = 1'b0;
    endtask

    // Drives one full proof and checks every round polynomial plus the final values.
    task automatic run_proof(input bit hold, input bit poke, input bit slow);
        longint unsigned s0, s1, s2, a0, a1, b0, b1, r;
        int len;
        int cnt;
        logic [2:0][31:0] snap;
        for (int i = 0; i < N; i++) begin
            ma[i] = 64'(ta[i]) % M;
            mb[i] = 64'(tbv[i]) % M;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        if (poke) begin
            check("busy_in_eval", 96'(busy), 96'(1));
            start = 1'b1; load_valid = 1'b1; load_idx = '0; load_a = 32'd999; load_b = 32'd999;
            tick();
            start = 1'b0; load_valid = 1'b0;
        end
        len = N;
        for (int j = 0; j < NB; j++) begin
            s0 = 0; s1 = 0; s2 = 0;
            for (int p = 0; p < len / 2; p++) begin
                a0 = ma[2*p]; a1 = ma[2*p+1]; b0 = mb[2*p]; b1 = mb[2*p+1];
                s0 = (s0 + a0 * b0) % M;
                s1 = (s1 + a1 * b1) % M;
                s2 = (s2 + ((2 * a1 + M - a0) % M) * ((2 * b1 + M - b0) % M)) % M;
            end
            cnt = 0;
            while (!pts_valid && cnt < 200) begin tick(); cnt++; end
            check($sformatf("pts_valid_r%0d", j), 96'(pts_valid), 96'(1));
            check($sformatf("g0_r%0d", j), 96'(sample_pts[0]), 96'(s0));
            check($sformatf("g1_r%0d", j), 96'(sample_pts[1]), 96'(s1));
            check($sformatf("g2_r%0d", j), 96'(sample_pts[2]), 96'(s2));
            if (j == 0) first_pts = sample_pts;
            if (hold && j == 0) begin
                snap = sample_pts;
                chal_valid = 1'b1;
                challenge  = 32'd12345;
                repeat (5) tick();
                check("hold_pts_valid", 96'(pts_valid), 96'(1));
                check("hold_sample_pts", 96'(sample_pts), 96'(snap));
                check("chal_ready_in_send", 96'(chal_ready), 96'(0));
                chal_valid = 1'b0;
            end
            if (slow) repeat ($urandom_range(0, 3)) tick();
            pts_ready = 1'b1;
            tick();
            pts_ready = 1'b0;
            check($sformatf("pts_drop_r%0d", j), 96'(pts_valid), 96'(0));
            cnt = 0;
            while (!chal_ready && cnt < 50) begin tick(); cnt++; end
            check($sformatf("chal_ready_r%0d", j), 96'(chal_ready), 96'(1));
            if (slow) repeat ($urandom_range(0, 3)) tick();
            challenge  = chal[j];
            chal_valid = 1'b1;
            tick();
            chal_valid = 1'b0;
            r = 64'(chal[j]) % M;
            for (int p = 0; p < len / 2; p++) begin
                a0 = ma[2*p]; a1 = ma[2*p+1]; b0 = mb[2*p]; b1 = mb[2*p+1];
                ma[p] = (a0 + r * ((a1 + M - a0) % M)) % M;
                mb[p] = (b0 + r * ((b1 + M - b0) % M)) % M;
            end
            len = len / 2;
        end
        cnt = 0;
        while (!done && cnt < 200) begin tick(); cnt++; end
        check("done", 96'(done), 96'(1));
        check("final_a", 96'(final_a), 96'(ma[0]));
        check("final_b", 96'(final_b), 96'(mb[0]));
        check("busy_after_done", 96'(busy), 96'(0));
    endtask

    task automatic set_scenario1;
        for (int i = 0; i < N; i++) begin
            ta[i]  = 32'(i + 1);
            tbv[i] = 32'd1;
        end
        chal[0] = 32'd0; chal[1] = 32'd1; chal[2] = 32'd2;
    endtask

    initial begin
        int cnt;
        rst = 1'b1; load_valid = 1'b0; load_idx = '0; load_a = '0; load_b = '0;
        start = 1'b0; pts_ready = 1'b0; challenge = '0; chal_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_sample_pts", 96'(sample_pts), 96'(0));
        check("rst_pts_valid", 96'(pts_valid), 96'(0));
        check("rst_chal_ready", 96'(chal_ready), 96'(0));
        check("rst_final_a", 96'(final_a), 96'(0));
        check("rst_final_b", 96'(final_b), 96'(0));
        check("rst_done", 96'(done), 96'(0));
        check("rst_busy", 96'(busy), 96'(0));

        // Scenario 1 with a stalled SEND and a premature challenge.
        set_scenario1();
        load_all();
        run_proof(1'b1, 1'b0, 1'b0);
        check("s1_pts", 96'(first_pts), {32'd24, 32'd20, 32'd16});
        check("s1_final_a", 96'(final_a), 96'(11));
        check("s1_final_b", 96'(final_b), 96'(1));

        // Start and load pulses during EVAL must not disturb the proof.
        load_all();
        run_proof(1'b0, 1'b1, 1'b0);
        check("poke_final_a", 96'(final_a), 96'(11));

        // Subtraction wrap in the x=2 sample point.
        for (int i = 0; i < N; i++) begin
            ta[i]  = 32'd0;
            tbv[i] = 32'd1;
        end
        ta[0] = 32'(M - 1);
        for (int j = 0; j < NB; j++) chal[j] = $urandom;
        load_all();
        run_proof(1'b0, 1'b0, 1'b0);
        check("wrap_pts", 96'(first_pts), {32'd1, 32'd0, 32'(M - 1)});

        // Reset during the round-2 fold, then reload and rerun.
        set_scenario1();
        load_all();
        start = 1'b1; tick(); start = 1'b0;
        for (int j = 0; j < 2; j++) begin
            cnt = 0;
            while (!pts_valid && cnt < 200) begin tick(); cnt++; end
            pts_ready = 1'b1; tick(); pts_ready = 1'b0;
            cnt = 0;
            while (!chal_ready && cnt < 50) begin tick(); cnt++; end
            challenge = chal[j]; chal_valid = 1'b1; tick(); chal_valid = 1'b0;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 96'(busy), 96'(0));
        check("midrst_pts_valid", 96'(pts_valid), 96'(0));
        check("midrst_done", 96'(done), 96'(0));
        check("midrst_chal_ready", 96'(chal_ready), 96'(0));
        load_all();
        run_proof(1'b0, 1'b0, 1'b0);
        check("rerun_final_a", 96'(final_a), 96'(11));

        // Unreduced challenge in the last round.
        set_scenario1();
        chal[2] = 32'(M + 2);
        load_all();
        run_proof(1'b0, 1'b0, 1'b1);
        check("bigchal_final_a", 96'(final_a), 96'(11));

        // Random tables and challenges with random handshake delays.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < N; i++) begin
                ta[i]  = $urandom;
                tbv[i] = $urandom;
            end
            for (int j = 0; j < NB; j++) chal[j] = $urandom;
            load_all();
            run_proof(1'b0, 1'b0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
